// File: rtl/seg7_scan_driver_if.sv
// Bundle of control inputs and display outputs for seg7_scan_driver.
// The master side drives value/control; the slave side is the scan driver.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_en;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic [IW-1:0]         digit_idx;

  modport master (
    output en, load, value, dp_in, lz_en,
    input  seg, dp, an, digit_idx
  );

  modport slave (
    input  en, load, value, dp_in, lz_en,
    output seg, dp, an, digit_idx
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment driver: shadow-latched value, prescaled digit
// scan, leading-zero suppression, per-digit decimal point, selectable polarity.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1
) (
  input  logic              clock,
  input  logic              reset,
  seg7_scan_driver_if.slave bus
);
  localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int   PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic OFF = ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic {
    SCAN_RUN,
    SCAN_HOLD
  } scan_state_t;

  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  scan_state_t         state;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                all_zero;
  logic [DIGITS-1:0]   an_oh;
  logic [6:0]          seg_al;

  // Internal decode is active-low; polarity is applied once at the output register.
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40;
      4'h1: enc = 7'h79;
      4'h2: enc = 7'h24;
      4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;
      4'h5: enc = 7'h12;
      4'h6: enc = 7'h02;
      4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;
      4'h9: enc = 7'h10;
      4'hA: enc = 7'h08;
      4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;
      4'hD: enc = 7'h21;
      4'hE: enc = 7'h06;
      default: enc = 7'h0E;
    endcase
  endfunction

  // Walk from the most significant digit down so all_zero covers "this and all higher".
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    all_zero  = 1'b1;
    an_oh     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (shadow_val[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        cur_nib   = shadow_val[4*i +: 4];
        cur_dp    = shadow_dp[i];
        cur_blank = bus.lz_en && all_zero && (i > 0);
        an_oh[i]  = 1'b1;
      end
    end
    seg_al = cur_blank ? 7'h7F : enc(cur_nib);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_val    <= '0;
      shadow_dp     <= '0;
      presc         <= '0;
      idx           <= '0;
      state         <= SCAN_HOLD;
      bus.seg       <= {7{OFF}};
      bus.dp        <= OFF;
      bus.an        <= {DIGITS{OFF}};
      bus.digit_idx <= '0;
    end else begin
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_in;
      end
      state         <= bus.en ? SCAN_RUN : SCAN_HOLD;
      bus.digit_idx <= idx;
      if (bus.en) begin
        if (presc == PW'(REFRESH_DIV - 1)) begin
          presc <= '0;
          idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
        bus.seg <= ACTIVE_LOW ? seg_al  : ~seg_al;
        bus.dp  <= ACTIVE_LOW ? ~cur_dp : cur_dp;
        bus.an  <= ACTIVE_LOW ? ~an_oh  : an_oh;
      end else begin
        bus.seg <= {7{OFF}};
        bus.dp  <= OFF;
        bus.an  <= {DIGITS{OFF}};
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit active-low scanner plus
// 1-digit active-low and active-high instances for the encoding sweep.
module tb_seg7_scan_driver;
  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [6:0] obs_seg [4];
  logic       obs_dp  [4];
  logic [3:0] seen;

  always #5 clock = ~clock;

  seg7_scan_driver_if #(.DIGITS(4)) ifa ();
  seg7_scan_driver_if #(.DIGITS(1)) ifb ();
  seg7_scan_driver_if #(.DIGITS(1)) ifc ();

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa));
  seg7_scan_driver #(.DIGITS(1), .REFRESH_DIV(1), .ACTIVE_LOW(1)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb));
  seg7_scan_driver #(.DIGITS(1), .REFRESH_DIV(1), .ACTIVE_LOW(0)) dut_c (
    .clock(clock), .reset(reset), .bus(ifc));

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Sweep one full 16-cycle scan of instance A, recording seg/dp per digit seen.
  task automatic collect_a();
    logic [3:0] pat;
    seen = '0;
    for (int c = 0; c < 16; c++) begin
      for (int d = 0; d < 4; d++) begin
        pat = 4'b0001 << d;
        pat = ~pat;
        if (ifa.an == pat) begin
          obs_seg[d] = ifa.seg;
          obs_dp[d]  = ifa.dp;
          seen[d]    = 1'b1;
        end
      end
      step();
    end
  endtask

  task automatic load_a(input logic [15:0] v, input logic [3:0] dpv);
    ifa.value = v;
    ifa.dp_in = dpv;
    ifa.load  = 1'b1;
    step();
    ifa.load  = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] exp_an;
    int d;
    reset = 1'b1;
    ifa.en = 1'b1; ifa.load = 1'b0; ifa.value = '0; ifa.dp_in = '0; ifa.lz_en = 1'b0;
    ifb.en = 1'b1; ifb.load = 1'b0; ifb.value = '0; ifb.dp_in = '0; ifb.lz_en = 1'b0;
    ifc.en = 1'b1; ifc.load = 1'b0; ifc.value = '0; ifc.dp_in = '0; ifc.lz_en = 1'b0;
    repeat (3) step();
    total++; if (ifa.seg !== 7'h7F) begin bad++; $display("[TB] FAIL reset_seg_a got=%h exp=7f", ifa.seg); end
    total++; if (ifa.an !== 4'hF) begin bad++; $display("[TB] FAIL reset_an_a got=%h exp=f", ifa.an); end
    total++; if (ifa.dp !== 1'b1) begin bad++; $display("[TB] FAIL reset_dp_a got=%b exp=1", ifa.dp); end
    total++; if (ifa.digit_idx !== 2'd0) begin bad++; $display("[TB] FAIL reset_idx_a got=%0d exp=0", ifa.digit_idx); end
    total++; if (ifc.seg !== 7'h00 || ifc.an !== 1'b0 || ifc.dp !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_c got seg=%h an=%b dp=%b exp 00/0/0", ifc.seg, ifc.an, ifc.dp);
    end
    reset = 1'b0;
    ifa.en = 1'b0;
    ifa.value = 16'h1234;
    ifa.load = 1'b1;
    step();
    total++; if (ifa.an !== 4'hF) begin bad++; $display("[TB] FAIL disabled_an got=%h exp=f", ifa.an); end
    ifa.load = 1'b0;
    ifa.en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      d = ((n - 1) / 4) % 4;
      exp_an = 4'b0001 << d;
      exp_an = ~exp_an;
      total++; if (ifa.an !== exp_an) begin bad++; $display("[TB] FAIL scan_an n=%0d got=%h exp=%h", n, ifa.an, exp_an); end
      total++; if (ifa.seg !== exp_seg[d]) begin bad++; $display("[TB] FAIL scan_seg n=%0d got=%h exp=%h", n, ifa.seg, exp_seg[d]); end
      total++; if (ifa.digit_idx !== 2'(d)) begin bad++; $display("[TB] FAIL scan_idx n=%0d got=%0d exp=%0d", n, ifa.digit_idx, d); end
    end
  endtask

  task automatic test_encoding();
    for (int v = 0; v < 16; v++) begin
      ifb.value = 4'(v); ifc.value = 4'(v);
      ifb.load = 1'b1;   ifc.load = 1'b1;
      step();
      ifb.load = 1'b0;   ifc.load = 1'b0;
      step();
      total++; if (ifb.seg !== tbl[v]) begin bad++; $display("[TB] FAIL enc_low v=%h got=%h exp=%h", v, ifb.seg, tbl[v]); end
      total++; if (ifc.seg !== ~tbl[v]) begin bad++; $display("[TB] FAIL enc_high v=%h got=%h exp=%h", v, ifc.seg, ~tbl[v]); end
      total++; if (ifb.an !== 1'b0 || ifc.an !== 1'b1) begin
        bad++; $display("[TB] FAIL enc_an v=%h got b=%b c=%b exp b=0 c=1", v, ifb.an, ifc.an);
      end
      total++; if (ifb.dp !== 1'b1 || ifc.dp !== 1'b0) begin
        bad++; $display("[TB] FAIL enc_dp v=%h got b=%b c=%b exp b=1 c=0", v, ifb.dp, ifc.dp);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] e1 [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic [6:0] e2 [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    ifa.lz_en = 1'b1;
    load_a(16'h0050, 4'b0000);
    collect_a();
    total++; if (seen !== 4'hF) begin bad++; $display("[TB] FAIL lz1_seen got=%h exp=f", seen); end
    for (int d = 0; d < 4; d++) begin
      total++; if (obs_seg[d] !== e1[d]) begin bad++; $display("[TB] FAIL lz_0050 d=%0d got=%h exp=%h", d, obs_seg[d], e1[d]); end
    end
    load_a(16'h0000, 4'b0000);
    collect_a();
    for (int d = 0; d < 4; d++) begin
      total++; if (obs_seg[d] !== e2[d]) begin bad++; $display("[TB] FAIL lz_0000 d=%0d got=%h exp=%h", d, obs_seg[d], e2[d]); end
    end
    ifa.lz_en = 1'b0;
    step();
    collect_a();
    for (int d = 0; d < 4; d++) begin
      total++; if (obs_seg[d] !== 7'h40) begin bad++; $display("[TB] FAIL lz_off d=%0d got=%h exp=40", d, obs_seg[d]); end
    end
  endtask

  task automatic test_decimal_point();
    logic edp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    ifa.lz_en = 1'b1;
    load_a(16'h0000, 4'b0100);
    collect_a();
    total++; if (seen !== 4'hF) begin bad++; $display("[TB] FAIL dp_seen got=%h exp=f", seen); end
    for (int d = 0; d < 4; d++) begin
      total++; if (obs_dp[d] !== edp[d]) begin bad++; $display("[TB] FAIL dp d=%0d got=%b exp=%b", d, obs_dp[d], edp[d]); end
    end
    total++; if (obs_seg[2] !== 7'h7F) begin bad++; $display("[TB] FAIL dp_seg2 got=%h exp=7f", obs_seg[2]); end
    ifa.lz_en = 1'b0;
  endtask

  task automatic test_enable_load();
    bit found;
    load_a(16'h5678, 4'b0000);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (ifa.an == 4'h7) found = 1'b1; else step();
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL wait_digit3 got=timeout exp=an 7"); end
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (ifa.an == 4'hB) found = 1'b1; else step();
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL wait_digit2 got=timeout exp=an b"); end
    step();
    total++; if (ifa.an !== 4'hB || ifa.seg !== 7'h02) begin
      bad++; $display("[TB] FAIL mid_digit2 got an=%h seg=%h exp an=b seg=02", ifa.an, ifa.seg);
    end
    ifa.en = 1'b0;
    step();
    total++; if (ifa.an !== 4'hF || ifa.seg !== 7'h7F || ifa.dp !== 1'b1) begin
      bad++; $display("[TB] FAIL en_off got an=%h seg=%h dp=%b exp f/7f/1", ifa.an, ifa.seg, ifa.dp);
    end
    total++; if (ifa.digit_idx !== 2'd2) begin bad++; $display("[TB] FAIL en_off_idx got=%0d exp=2", ifa.digit_idx); end
    step(); step();
    total++; if (ifa.an !== 4'hF) begin bad++; $display("[TB] FAIL en_hold got=%h exp=f", ifa.an); end
    ifa.en = 1'b1;
    step();
    total++; if (ifa.an !== 4'hB) begin bad++; $display("[TB] FAIL resume1 got=%h exp=b", ifa.an); end
    step();
    total++; if (ifa.an !== 4'hB) begin bad++; $display("[TB] FAIL resume2 got=%h exp=b", ifa.an); end
    step();
    total++; if (ifa.an !== 4'h7 || ifa.seg !== 7'h12) begin
      bad++; $display("[TB] FAIL resume3 got an=%h seg=%h exp an=7 seg=12", ifa.an, ifa.seg);
    end
    ifa.value = 16'hABCD;
    ifa.load  = 1'b1;
    step();
    ifa.load  = 1'b0;
    step();
    total++; if (ifa.an !== 4'h7 || ifa.seg !== 7'h08) begin
      bad++; $display("[TB] FAIL load_mid got an=%h seg=%h exp an=7 seg=08", ifa.an, ifa.seg);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    ifa.value = 16'hFFFF;
    ifa.load  = 1'b1;
    step();
    total++; if (ifa.an !== 4'hF || ifa.seg !== 7'h7F || ifa.dp !== 1'b1 || ifa.digit_idx !== 2'd0) begin
      bad++; $display("[TB] FAIL rst_prio got an=%h seg=%h dp=%b idx=%0d exp f/7f/1/0",
                      ifa.an, ifa.seg, ifa.dp, ifa.digit_idx);
    end
    reset = 1'b0;
    ifa.load = 1'b0;
    step();
    total++; if (ifa.an !== 4'hE || ifa.seg !== 7'h40 || ifa.digit_idx !== 2'd0) begin
      bad++; $display("[TB] FAIL rst_after got an=%h seg=%h idx=%0d exp e/40/0", ifa.an, ifa.seg, ifa.digit_idx);
    end
  endtask

  initial begin
    $display("[TB] starting seg7_scan_driver bench");
    test_reset();
    test_encoding();
    test_leading_zero();
    test_decimal_point();
    test_enable_load();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
